mdu_ctrl: RTL and testbench

Multiply/divide controller for the extended MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decode stage and sequences an iterative 32-step shift-add multiplier / restoring divider. It owns the HI/LO registers and generates the pipeline stall for HI/LO hazards. It sits beside the ALU in `pipeline`, between `idecode` operand read and the writeback mux that serves MFHI/MFLO.

---
 rtl/mdu_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: 32-step shift-add multiplier / restoring divider owning HI/LO.
// Define MDU_DIV_EN to build the divider (DIV/DIVU); otherwise those ops decode as NOP.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg_q;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_op_mul;
    logic                 w_op_div;
    logic                 w_op_move;
    logic                 w_op_signed;
    logic                 w_start;
    logic                 w_stall;
    logic [WIDTH-1:0]     w_rs_abs;
    logic [WIDTH-1:0]     w_rt_abs;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

`ifdef MDU_DIV_EN
    logic                 r_is_div;
    logic                 r_neg_r;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_op_div = (op == OP_DIV) || (op == OP_DIVU);
`else
    assign w_op_div = 1'b0;
`endif

    assign w_op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign w_op_move   = (op == OP_MTHI) || (op == OP_MTLO);
    assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_start     = (r_state == S_IDLE) && op_valid && (w_op_mul || w_op_div);

    assign w_rs_abs = (w_op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_abs = (w_op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Multiply keeps {partial, multiplier} in r_acc and retires one multiplier bit per step.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    // Divide keeps {remainder, dividend/quotient}; a zero divisor always "fits", giving all-ones.
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_trial - {1'b0, r_mcand};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
    assign w_step      = r_is_div ? w_div_next : w_mul_next;
`else
    assign w_step      = w_mul_next;
`endif

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            w_res_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == '0) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Only ops that touch HI/LO or need the sequencer can collide with an in-flight op.
    always_comb begin
        w_stall = r_busy && (mf_req || (op_valid && (w_op_mul || w_op_div || w_op_move)));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= CW'(WIDTH - 1);
                        // A zero divisor must leave the quotient as raw all-ones.
                        r_neg_q <= w_op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]) && (|rt_val);
`ifdef MDU_DIV_EN
                        r_is_div <= w_op_div;
                        r_neg_r  <= w_op_signed && rs_val[WIDTH-1];
                        r_mcand  <= w_op_div ? w_rt_abs : w_rs_abs;
                        r_acc    <= {{WIDTH{1'b0}}, (w_op_div ? w_rs_abs : w_rt_abs)};
`else
                        r_mcand  <= w_rs_abs;
                        r_acc    <= {{WIDTH{1'b0}}, w_rt_abs};
`endif
                    end else if (op_valid && (op == OP_MTHI)) begin
                        r_hi <= rs_val;
                    end else if (op_valid && (op == OP_MTLO)) begin
                        r_lo <= rs_val;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign stall = w_stall;
    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops against
// an arithmetic reference model of HI/LO (follows MDU_DIV_EN like the design).
module tb_mdu_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         mf_req;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mf_req   (mf_req),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: MIPS HI/LO semantics in plain 64-bit / signed-int arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output bit iter);
        logic [63:0] p;
        longint      sp;
        int          sa;
        int          sb;
        iter = 1'b0;
        sa   = a;
        sb   = b;
        case (o)
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = sp;
                iter = 1'b1;
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
                iter = 1'b1;
            end
`ifdef MDU_DIV_EN
            3'd3: begin
                iter = 1'b1;
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = '0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd4: begin
                iter = 1'b1;
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
`endif
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from IDLE; for iterative ops hold mf_req through the run and time busy/stall.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        bit iter;
        int n_busy;
        int n_stall;
        bit done_early;
        model(o, a, b, iter);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        mf_req   = 1'($urandom_range(0, 1));
        #1;
        check({tag, "_idle_stall"}, 64'(stall), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        mf_req   = iter;
        #1;
        n_busy = 0;
        n_stall = 0;
        done_early = 1'b0;
        while (busy === 1'b1 && n_busy < 100) begin
            n_busy++;
            n_stall += int'(stall);
            done_early |= done;
            @(negedge clk);
            #1;
        end
        if (iter) begin
            check({tag, "_busy_len"}, 64'(n_busy), 64'd33);
            check({tag, "_stall_len"}, 64'(n_stall), 64'd33);
            check({tag, "_done_early"}, 64'(done_early), 64'd0);
            check({tag, "_done"}, 64'(done), 64'd1);
            check({tag, "_mf_stall"}, 64'(stall), 64'd0);
            check({tag, "_hi"}, 64'(hi), 64'(m_hi));
            check({tag, "_lo"}, 64'(lo), 64'(m_lo));
            @(negedge clk);
            mf_req = 1'b0;
            #1;
            check({tag, "_done_clr"}, 64'(done), 64'd0);
        end else begin
            check({tag, "_busy_len"}, 64'(n_busy), 64'd0);
            check({tag, "_done"}, 64'(done), 64'd0);
            check({tag, "_hi"}, 64'(hi), 64'(m_hi));
            check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        end
        mf_req = 1'b0;
    endtask

    // MULT, then a second op held by decode while busy; it must execute right after done.
    task automatic busy_then(input string tag, input logic [2:0] o2, input logic [W-1:0] a2);
        bit iter;
        int n_busy;
        int n_stall;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit exp_stall;
        a = pick_operand();
        b = pick_operand();
        exp_stall = (o2 == 3'd5) || (o2 == 3'd6);
        model(3'd1, a, b, iter);
        @(negedge clk);
        op_valid = 1'b1;
        op       = 3'd1;
        rs_val   = a;
        rt_val   = b;
        @(negedge clk);
        op     = o2;
        rs_val = a2;
        rt_val = pick_operand();
        #1;
        n_busy = 0;
        n_stall = 0;
        while (busy === 1'b1 && n_busy < 100) begin
            n_busy++;
            n_stall += int'(stall);
            @(negedge clk);
            #1;
        end
        check({tag, "_busy_len"}, 64'(n_busy), 64'd33);
        check({tag, "_stall_len"}, 64'(n_stall), exp_stall ? 64'd33 : 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall_after"}, 64'(stall), 64'd0);
        check({tag, "_prod_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_prod_lo"}, 64'(lo), 64'(m_lo));
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        model(o2, a2, rt_val, iter);
        check({tag, "_move_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_move_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_move_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [2:0] o;
        logic [2:0] second_ops[$];
        logic [2:0] long_op;

        rst      = 1'b0;
        op_valid = 1'b0;
        op       = '0;
        rs_val   = '0;
        rt_val   = '0;
        mf_req   = 1'b1;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        mf_req = 1'b0;

        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", 3'd4, 32'h0000_1234, 32'd0);
        run_op("div_zero", 3'd3, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mthi", 3'd5, 32'hCAFE_BABE, 32'd0);
        run_op("mtlo", 3'd6, 32'h1357_9BDF, 32'd0);
        run_op("reserved", 3'd7, 32'h1111_1111, 32'd3);

        second_ops = '{3'd0, 3'd5, 3'd6, 3'd7};
`ifndef MDU_DIV_EN
        second_ops.push_back(3'd3);
        second_ops.push_back(3'd4);
`endif
        busy_then("mtlo_busy", 3'd6, 32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) begin
            busy_then("b2b", second_ops[$urandom_range(0, second_ops.size() - 1)], $urandom);
        end

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            run_op("rand", o, pick_operand(), pick_operand());
        end

        run_op("pre_rst_hi", 3'd5, 32'hA5A5_0001, 32'd0);
        run_op("pre_rst_lo", 3'd6, 32'h5A5A_0002, 32'd0);
`ifdef MDU_DIV_EN
        long_op = 3'd3;
`else
        long_op = 3'd1;
`endif
        @(negedge clk);
        op_valid = 1'b1;
        op       = long_op;
        rs_val   = 32'h0001_0000;
        rt_val   = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst    = 1'b0;
        mf_req = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst    = 1'b1;
        mf_req = 1'b0;
        @(negedge clk);
        #1;
        check("postrst_busy", 64'(busy), 64'd0);
        run_op("multu_2x3", 3'd2, 32'd2, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
